// File: rtl/lcd_char_ctrl_if.sv
// Byte-stream handshake between the host side and the HD44780 controller.
// master: byte producer; slave: lcd_char_ctrl.
`timescale 1ns/1ps
interface lcd_char_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;

    modport master (output in_valid, output in_rs, output in_data, input in_ready);
    modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_char_ctrl.sv
// HD44780 16x2 character-LCD controller, 8-bit write-only bus.
// Runs the power-up init sequence, then writes command/data bytes taken from a
// valid/ready stream, generating setup/strobe/hold and post-write delays in hardware.
// Optional feature macro: LCD_BACKLIGHT_CTRL_EN (adds bl_on input driving LCD_BLON).
`timescale 1ns/1ps
module lcd_char_ctrl #(
    parameter int unsigned SETUP_CYC     = 3,
    parameter int unsigned EN_HIGH_CYC   = 12,
    parameter int unsigned HOLD_CYC      = 3,
    parameter int unsigned CMD_WAIT_CYC  = 2500,
    parameter int unsigned CLR_WAIT_CYC  = 82000,
    parameter int unsigned PWRUP_CYC     = 750000,
    // First Function Set needs >4.1 ms before the next write
    parameter int unsigned INIT0_WAIT_CYC = 205000
) (
    input  logic           clk,
    input  logic           reset_n,
    lcd_char_ctrl_if.slave bus,
`ifdef LCD_BACKLIGHT_CTRL_EN
    input  logic           bl_on,
`endif
    output logic           init_done,
    output logic           LCD_ON,
    output logic           LCD_BLON,
    output logic           LCD_EN,
    output logic           LCD_RW,
    output logic           LCD_RS,
    output logic [7:0]     LCD_DATA
);

    localparam int unsigned MAX_A   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
    localparam int unsigned MAX_B   = (INIT0_WAIT_CYC > CMD_WAIT_CYC) ? INIT0_WAIT_CYC : CMD_WAIT_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          CNT_W   = $clog2(MAX_CYC + 1);

    // Counter reload values: a state loaded with N-1 lasts exactly N clocks
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_INIT0 = CNT_W'(INIT0_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_CYC - 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAIT
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic             done_next;
    logic             rs_next;
    logic [7:0]       data_next;
    logic             en_next;
    logic             handshake;
    logic [CNT_W-1:0] wait_load;

    function automatic logic [7:0] init_rom(input logic [2:0] i);
        logic [7:0] v;
        case (i)
            3'd0, 3'd1, 3'd2: v = 8'h38;
            3'd3:             v = 8'h0C;
            3'd4:             v = 8'h01;
            default:          v = 8'h06;
        endcase
        return v;
    endfunction

    assign LCD_ON       = 1'b1;
    assign LCD_RW       = 1'b0;
    assign bus.in_ready = (state == S_IDLE) && init_done;
    assign handshake    = (state == S_IDLE) && init_done && bus.in_valid;

    // Post-write delay for the byte currently on the bus
    always_comb begin
        wait_load = LD_CMD;
        if (!init_done && (idx == 3'd0))
            wait_load = LD_INIT0;
        else if (!LCD_RS && (LCD_DATA == 8'h01 || LCD_DATA == 8'h02 || LCD_DATA == 8'h03))
            wait_load = LD_CLR;
    end

    // Next-state logic: sequencing, counter reloads, bus register loads
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        done_next  = init_done;
        rs_next    = LCD_RS;
        data_next  = LCD_DATA;
        case (state)
            S_PWRUP: begin
                if (cnt == '0) begin
                    state_next = S_INIT;
                    idx_next   = 3'd0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_INIT: begin
                rs_next    = 1'b0;
                data_next  = init_rom(idx);
                state_next = S_SETUP;
                cnt_next   = LD_SETUP;
            end
            S_IDLE: begin
                if (handshake) begin
                    rs_next    = bus.in_rs;
                    data_next  = bus.in_data;
                    state_next = S_SETUP;
                    cnt_next   = LD_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_next = S_STROBE;
                    cnt_next   = LD_EN;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt == '0) begin
                    state_next = S_HOLD;
                    cnt_next   = LD_HOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_next = S_WAIT;
                    cnt_next   = wait_load;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    if (init_done) begin
                        state_next = S_IDLE;
                    end else if (idx == 3'd5) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        idx_next   = idx + 3'd1;
                        state_next = S_INIT;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = S_PWRUP;
        endcase
        // EN is registered so the pin never glitches on state decode
        en_next = (state_next == S_STROBE);
    end

    // State, counter and LCD bus registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_PWRUP;
            cnt       <= LD_PWRUP;
            idx       <= 3'd0;
            init_done <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_DATA  <= 8'h00;
            LCD_EN    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            init_done <= done_next;
            LCD_RS    <= rs_next;
            LCD_DATA  <= data_next;
            LCD_EN    <= en_next;
        end
    end

`ifdef LCD_BACKLIGHT_CTRL_EN
    logic blon_reg;

    // Backlight follows bl_on with one clock of latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            blon_reg <= 1'b0;
        else
            blon_reg <= bl_on;
    end

    assign LCD_BLON = blon_reg;
`else
    assign LCD_BLON = 1'b1;
`endif

endmodule
